// File: rtl/key_debounce_if.sv
// Key debouncer bundle: raw asynchronous keys in, debounced levels/events out.
interface key_debounce_if;
    logic [2:0] key_in;
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [2:0] key_release;
    logic [2:0] key_toggle;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_toggle
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_toggle
    );
endinterface

// File: rtl/key_debounce.sv
// Three-channel push-button debouncer: two-flop synchronizer, per-channel
// stability counter, and registered press/release pulses plus a toggle level.
module key_debounce #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_W           = 20,
    parameter logic PRESSED_LEVEL   = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    key_debounce_if.slave  kif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [2:0]       RELEASED_RAW = {3{~PRESSED_LEVEL}};

    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       level_q, level_d;
    logic [2:0]       press_q, press_d;
    logic [2:0]       release_q, release_d;
    logic [2:0]       toggle_q, toggle_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       sync_pressed;

    // Next-state: synchronize, then count consecutive disagreeing cycles per channel.
    always_comb begin
        sync1_d      = kif.key_in;
        sync2_d      = sync1_q;
        sync_pressed = PRESSED_LEVEL ? sync2_q : ~sync2_q;
        level_d      = level_q;
        press_d      = '0;
        release_d    = '0;
        toggle_d     = toggle_q ^ press_q;
        for (int unsigned i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync_pressed[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i]   = sync_pressed[i];
                    press_d[i]   = sync_pressed[i];
                    release_d[i] = ~sync_pressed[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // State registers; reset forces synchronizers to released and clears everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= RELEASED_RAW;
            sync2_q   <= RELEASED_RAW;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
            cnt_q     <= '{default: '0};
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
            cnt_q     <= cnt_d;
        end
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_toggle  = toggle_q;

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce: sliding-window reference model plus directed scenarios.
module tb_key_debounce;

    localparam int   D       = 4;
    localparam logic P_LEVEL = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    key_debounce_if kif ();

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3),
        .PRESSED_LEVEL(P_LEVEL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kif(kif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a channel's level flips when the last D synchronized
    // samples (raw delayed two edges) all disagree with the current level.
    logic [2:0] m_level = '0, m_press = '0, m_release = '0, m_toggle = '0;
    logic [2:0] hist [$];
    logic [2:0] s_raw;
    logic       s_rstn;
    logic       flip;
    int         idx;
    int         press_seen [3];
    int         rel_seen [3];

    always @(posedge clk) begin
        s_raw  = kif.key_in;
        s_rstn = rst_n;
        if (!s_rstn) begin
            m_level = '0; m_press = '0; m_release = '0; m_toggle = '0;
            hist.delete();
        end else begin
            m_toggle = m_toggle ^ m_press;
            m_press = '0;
            m_release = '0;
            hist.push_back(s_raw);
            for (int ch = 0; ch < 3; ch++) begin
                flip = 1'b1;
                for (int j = 0; j < D; j++) begin
                    idx = hist.size() - 3 - j;
                    if (idx < 0) flip = 1'b0;
                    else if ((hist[idx][ch] == P_LEVEL) == m_level[ch]) flip = 1'b0;
                end
                if (flip) begin
                    m_level[ch]   = ~m_level[ch];
                    m_press[ch]   = m_level[ch];
                    m_release[ch] = ~m_level[ch];
                end
            end
            if (hist.size() > D + 4) void'(hist.pop_front());
        end
        #1;
        check("level",   32'(kif.key_level),   32'(m_level));
        check("press",   32'(kif.key_press),   32'(m_press));
        check("release", 32'(kif.key_release), 32'(m_release));
        check("toggle",  32'(kif.key_toggle),  32'(m_toggle));
        check("press_and_release_exclusive", 32'(kif.key_press & kif.key_release), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("counter_bound", 32'(int'(dut.cnt_q[i]) > D - 1), 32'd0);
            if (kif.key_press[i])   press_seen[i]++;
            if (kif.key_release[i]) rel_seen[i]++;
        end
    end

    task automatic clear_seen();
        for (int i = 0; i < 3; i++) begin
            press_seen[i] = 0;
            rel_seen[i] = 0;
        end
    endtask

    task automatic zero_outputs(input string name);
        check(name, 32'({kif.key_level, kif.key_press, kif.key_release, kif.key_toggle}), 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        zero_outputs("async_reset_outputs");
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        kif.key_in = 3'b111;
        for (int i = 0; i < 3; i++) begin
            press_seen[i] = 0;
            rel_seen[i] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        zero_outputs("reset_state");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean press on key 1: level at edge 6, toggle at edge 7.
        kif.key_in[1] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #2;
            check("clean_level1",  32'(kif.key_level[1]),  32'(e >= 6));
            check("clean_press1",  32'(kif.key_press[1]),  32'(e == 6));
            check("clean_toggle1", 32'(kif.key_toggle[1]), 32'(e >= 7));
        end
        @(negedge clk);
        kif.key_in[1] = 1'b1;
        repeat (10) @(negedge clk);

        // Bounce on key 0: 0 x3, 1 x1, then 0 held.
        clear_seen();
        kif.key_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        kif.key_in[0] = 1'b1;
        @(negedge clk);
        kif.key_in[0] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #2;
            check("bounce_press0", 32'(kif.key_press[0]), 32'(e == 6));
        end
        check("bounce_press_count0", 32'(press_seen[0]), 32'd1);
        @(negedge clk);
        kif.key_in[0] = 1'b1;
        repeat (10) @(negedge clk);

        // Two clean press/release cycles on key 2.
        clear_seen();
        for (int r = 0; r < 2; r++) begin
            kif.key_in[2] = 1'b0;
            repeat (8) @(negedge clk);
            kif.key_in[2] = 1'b1;
            repeat (8) @(negedge clk);
        end
        check("twice_press_count2",   32'(press_seen[2]), 32'd2);
        check("twice_release_count2", 32'(rel_seen[2]),   32'd2);
        check("twice_toggle2",        32'(kif.key_toggle[2]), 32'd0);

        // All three pressed together from a fresh reset.
        do_reset(2);
        @(negedge clk);
        kif.key_in = 3'b000;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #2;
            check("all_press",  32'(kif.key_press),  (e == 6) ? 32'h7 : 32'h0);
            check("all_level",  32'(kif.key_level),  (e >= 6) ? 32'h7 : 32'h0);
            check("all_toggle", 32'(kif.key_toggle), (e >= 7) ? 32'h7 : 32'h0);
        end
        @(negedge clk);
        kif.key_in = 3'b111;
        repeat (10) @(negedge clk);

        // Long hold on key 1: exactly one press.
        clear_seen();
        kif.key_in[1] = 1'b0;
        repeat (1000) @(negedge clk);
        check("long_hold_press_count1", 32'(press_seen[1]), 32'd1);
        kif.key_in[1] = 1'b1;
        repeat (10) @(negedge clk);

        // Reset mid-count, then reset mid-pulse.
        do_reset(2);
        @(negedge clk);
        kif.key_in[1] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("midcount_counter", 32'(dut.cnt_q[1]), 32'd2);
        do_reset(3);
        check("midcount_counter_cleared", 32'(dut.cnt_q[1]), 32'd0);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #2;
            check("after_reset_press1", 32'(kif.key_press[1]), 32'(e == 6));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        zero_outputs("midpulse_reset_outputs");
        kif.key_in = 3'b111;
        repeat (2) @(negedge clk);
        clear_seen();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_spurious_press",   32'(press_seen[0] + press_seen[1] + press_seen[2]), 32'd0);
        check("no_spurious_release", 32'(rel_seen[0] + rel_seen[1] + rel_seen[2]), 32'd0);

        // Randomized bouncy/stable phases with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            int unsigned prob;
            prob = (seg % 2 == 0) ? 3 : 40;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 699) == 0) begin
                    rst_n = 1'b0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                end
                for (int b = 0; b < 3; b++) begin
                    if ($urandom_range(0, prob - 1) == 0) kif.key_in[b] = ~kif.key_in[b];
                end
            end
        end
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive clk cycles a synchronized key must differ from its debounced state before that state changes (10 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 20, is the debounce counter width; legal when 2 <= DEBOUNCE_CYCLES <= 2^CNT_W-1.
REQ-003 Parameter PRESSED_LEVEL, default 1'b0, is the raw key level meaning "pressed"; DE2 KEY buttons are active-low.
REQ-004 clk  input  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 key_in  input  3  raw push-buttons, asynchronous: [0] reset key, [1] start/pause key, [2] display-stop key.
REQ-007 key_level  output  3  debounced level per channel, 1 = pressed.
REQ-008 key_press  output  3  one-cycle pulse per channel on the debounced released->pressed transition.
REQ-009 key_release  output  3  one-cycle pulse per channel on the debounced pressed->released transition.
REQ-010 key_toggle  output  3  per-channel level that inverts on each key_press pulse; drives stopwatch run/pause and display freeze.

Function
REQ-011 Each channel shall pass key_in through a two-flop synchronizer; only the second flop output (sync) shall be used downstream.
REQ-012 Each channel shall hold a debounced state and a CNT_W-bit counter; the three channels shall be fully independent.
REQ-013 When sync equals the debounced state (after PRESSED_LEVEL mapping), the counter shall clear to 0 on the next edge.
REQ-014 When sync differs and the counter is below DEBOUNCE_CYCLES-1, the counter shall increment by 1.
REQ-015 When sync differs and the counter equals DEBOUNCE_CYCLES-1, the debounced state shall flip and the counter shall clear on the same edge.
REQ-016 Latency: a clean raw edge held stable shall change key_level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw value.
REQ-017 A glitch or bounce shorter than DEBOUNCE_CYCLES synchronized cycles shall not change key_level, key_press, key_release or key_toggle; any return to the debounced level restarts the count from 0.
REQ-018 key_press[i] shall be high for exactly the one cycle in which key_level[i] is first 1, registered alongside it; key_release[i] likewise for first 0.
REQ-019 key_toggle[i] shall invert on the edge after the cycle where key_press[i] is high; release shall not affect it.
REQ-020 key_press and key_release shall never be high together on one channel; a held key shall produce exactly one key_press with no repeat.
REQ-021 Simultaneous presses on several channels shall produce pulses on each affected channel in the same cycle, with no priority or masking.
REQ-022 The counter shall never exceed DEBOUNCE_CYCLES-1 and shall not wrap.
REQ-023 The block shall not generate derived or gated clocks.

Reset
REQ-024 While rst_n=0, all outputs shall be 0 immediately (asynchronously), synchronizer flops shall be at the released level (~PRESSED_LEVEL), and counters shall be 0.
REQ-025 On deassertion, operation shall start on the next rising edge; a key already held down at deassertion shall be debounced normally and shall produce one key_press after REQ-016 latency.
REQ-026 Reset asserted mid-count or mid-pulse shall abort the count and drop all pulses with no spurious pulse after release.

Verification (DEBOUNCE_CYCLES=4, PRESSED_LEVEL=0)
REQ-027 Reset, then drive key_in[1] 1->0 and hold -> key_level[1] rises 6 edges later, key_press[1] high exactly 1 cycle, key_toggle[1] 0->1 one cycle later.
REQ-028 Bounce on key_in[0]: 0 for 3 cycles, 1 for 1 cycle, 0 held -> no pulse during the bounce, and one key_press[0] 6 edges after the final falling edge.
REQ-029 Press then release key_in[2] cleanly twice -> two key_press and two key_release pulses; key_toggle[2] goes 0->1->0; never press and release together.
REQ-030 key_in=3'b000 applied in one cycle and held -> key_press=3'b111 for one cycle, key_level=3'b111, key_toggle=3'b111.
REQ-031 Hold key_in[1]=0 for 1000 cycles -> exactly one key_press[1]; the counter never exceeds 3.
REQ-032 Assert rst_n=0 at counter=2 with a key held, then release -> outputs 0 during reset; after release, a single key_press 6 edges later.
